// File: rtl/jump_wb_buffer_pkg.sv
// Shared definitions for the jump write-back buffer slice: register index
// width, FSM state encoding and a small destination-register helper.
package jump_wb_buffer_pkg;

  localparam int RD_W = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_FU = 1'b1
  } jwb_state_t;

  // x0 is hard-wired to zero, so a link into it never needs a write-back
  function automatic logic rd_writes(input logic [RD_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/jump_wb_buffer_wb_fifo.sv
// Small circular FIFO of {rd, link value} write-back entries. Storage is
// left unreset; only pointers and occupancy are cleared.
module wb_fifo
  import jump_wb_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int XLEN  = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [RD_W-1:0] push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [PTR_W:0]  count,
  output logic [RD_W-1:0] head_rd,
  output logic [XLEN-1:0] head_data
);

  logic [RD_W-1:0]  mem_rd   [DEPTH];
  logic [XLEN-1:0]  mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // a simultaneous pop frees the slot a full FIFO would otherwise lack
  assign do_push   = push && (!full || do_pop);
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jump_wb_buffer.sv
// Tracks one in-flight jump/branch, turns its completion into a registered
// fetch redirect and queues the link-register write for the register file.
module jump_wb_buffer
  import jump_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic [RD_W-1:0] iss_rd,
  input  logic            fu_finish,
  input  logic            fu_is_jump,
  input  logic [XLEN-1:0] fu_pc_jump,
  input  logic [XLEN-1:0] fu_pc_wb,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  localparam int PTR_W = $clog2(DEPTH);

  jwb_state_t      state;
  logic [RD_W-1:0] rd_q;
  logic            finish_acc;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [PTR_W:0]  fifo_count;
  logic            push_drop;

  assign busy       = (state == WAIT_FU) || (fifo_count == (PTR_W+1)'(DEPTH));
  assign wb_valid   = !fifo_empty;
  assign fifo_pop   = wb_valid && wb_ready;
  assign finish_acc = fu_finish && (state == WAIT_FU);
  assign fifo_push  = finish_acc && rd_writes(rd_q);
  assign push_drop  = fifo_push && fifo_full && !fifo_pop;

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_rd   (rd_q),
    .push_data (fu_pc_wb),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_rd   (wb_rd),
    .head_data (wb_data)
  );

  // err is sticky: stray issues, stray completions and dropped pushes all latch it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_q           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iss_en && !busy) begin
            rd_q  <= iss_rd;
            state <= WAIT_FU;
          end
        end
        WAIT_FU: begin
          if (fu_finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      redirect_valid <= finish_acc && fu_is_jump;
      if (finish_acc && fu_is_jump) redirect_pc <= fu_pc_jump;
      if ((iss_en && busy) || (fu_finish && state == IDLE) || push_drop) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_wb_buffer.sv
// Self-checking bench for jump_wb_buffer: directed vector table, reset
// corner cases and randomized traffic against a queue-based reference model.
module tb_jump_wb_buffer;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iss_en = 1'b0;
  logic [4:0]      iss_rd = '0;
  logic            fu_finish = 1'b0;
  logic            fu_is_jump = 1'b0;
  logic [XLEN-1:0] fu_pc_jump = '0;
  logic [XLEN-1:0] fu_pc_wb = '0;
  logic            wb_ready = 1'b0;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  jump_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iss_en         (iss_en),
    .iss_rd         (iss_rd),
    .fu_finish      (fu_finish),
    .fu_is_jump     (fu_is_jump),
    .fu_pc_jump     (fu_pc_jump),
    .fu_pc_wb       (fu_pc_wb),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Reference model: an in-flight flag, a queue of pending writes, and
  // the last redirect / sticky error as plain variables.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pending;
  logic [4:0]  m_rd;
  bit          m_redir_v;
  logic [31:0] m_redir_pc;
  bit          m_err;

  typedef struct {
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        fin;
    logic        jmp;
    logic [31:0] pcj;
    logic [31:0] pcwb;
    logic        rdy;
    logic        e_busy;
    logic        e_wbv;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rpc;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic ie, logic [4:0] ir, logic fin, logic jmp,
                               logic [31:0] pcj, logic [31:0] pcwb, logic rdy,
                               logic eb, logic ew, logic erv, logic ee,
                               logic [31:0] erpc, logic [4:0] erd, logic [31:0] edata);
    vec_t v;
    v.iss_en = ie; v.iss_rd = ir; v.fin = fin; v.jmp = jmp; v.pcj = pcj;
    v.pcwb = pcwb; v.rdy = rdy; v.e_busy = eb; v.e_wbv = ew; v.e_rv = erv;
    v.e_err = ee; v.e_rpc = erpc; v.e_rd = erd; v.e_data = edata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_pending  = 0;
    m_rd       = '0;
    m_redir_v  = 0;
    m_redir_pc = '0;
    m_err      = 0;
  endtask

  task automatic modelEdge();
    int sz;
    bit m_busy, do_pop, fin;
    ent_t e;
    if (!rst_n) begin
      modelReset();
    end else begin
      sz     = m_q.size();
      m_busy = m_pending || (sz == DEPTH);
      do_pop = (sz != 0) && wb_ready;
      fin    = fu_finish && m_pending;
      if (iss_en && m_busy) m_err = 1;
      if (fu_finish && !m_pending) m_err = 1;
      m_redir_v = fin && fu_is_jump;
      if (m_redir_v) m_redir_pc = fu_pc_jump;
      if (do_pop) void'(m_q.pop_front());
      if (fin && m_rd != 0) begin
        if (sz == DEPTH && !do_pop) m_err = 1;
        else begin
          e.rd = m_rd;
          e.data = fu_pc_wb;
          m_q.push_back(e);
        end
      end
      if (fin) m_pending = 0;
      else if (iss_en && !m_busy) begin
        m_pending = 1;
        m_rd = iss_rd;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'(m_pending || m_q.size() == DEPTH));
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_q.size() != 0));
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_redir_v));
    check({tag, ".redirect_pc"}, redirect_pc, m_redir_pc);
    check({tag, ".err"}, 32'(err), 32'(m_err));
    if (m_q.size() != 0) begin
      check({tag, ".wb_rd"}, 32'(wb_rd), 32'(m_q[0].rd));
      check({tag, ".wb_data"}, wb_data, m_q[0].data);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic clearInputs();
    iss_en = 0; iss_rd = '0; fu_finish = 0; fu_is_jump = 0;
    fu_pc_jump = '0; fu_pc_wb = '0; wb_ready = 0;
  endtask

  // Asserted between edges so the asynchronous path is what clears the outputs
  task automatic doReset(input string tag);
    clearInputs();
    rst_n = 0;
    #2;
    modelReset();
    check({tag, ".rst_busy"}, 32'(busy), 32'h0);
    check({tag, ".rst_wb_valid"}, 32'(wb_valid), 32'h0);
    check({tag, ".rst_redirect_valid"}, 32'(redirect_valid), 32'h0);
    check({tag, ".rst_redirect_pc"}, redirect_pc, 32'h0);
    check({tag, ".rst_err"}, 32'(err), 32'h0);
    applyStimulus({tag, ".in_reset"});
    rst_n = 1;
  endtask

  initial begin
    vec_t v;
    // rd=1 taken jump
    vecs.push_back(mkv(1, 5'd1, 0, 0, 0, 0, 1,          1, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 32'h200, 32'h104, 1, 0, 1, 1, 0, 32'h200, 1, 32'h104));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 32'h200, 0, 0));
    // rd=0 not-taken branch
    vecs.push_back(mkv(1, 5'd0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 32'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 32'h999, 32'h55, 1,  0, 0, 0, 0, 32'h200, 0, 0));
    // two writes held back by wb_ready=0, then drained in order
    vecs.push_back(mkv(1, 5'd3, 0, 0, 0, 0, 0,          1, 0, 0, 0, 32'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 32'h300, 32'h10, 0,  0, 1, 1, 0, 32'h300, 3, 32'h10));
    vecs.push_back(mkv(1, 5'd4, 0, 0, 0, 0, 0,          1, 1, 0, 0, 32'h300, 3, 32'h10));
    vecs.push_back(mkv(0, 0, 1, 0, 32'h777, 32'h20, 0,  1, 1, 0, 0, 32'h300, 3, 32'h10));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,             0, 1, 0, 0, 32'h300, 4, 32'h20));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 32'h300, 0, 0));
    // stray finish, then issue while busy: err sticks, latched rd unchanged
    vecs.push_back(mkv(0, 0, 1, 1, 32'h888, 32'h66, 0,  0, 0, 0, 1, 32'h300, 0, 0));
    vecs.push_back(mkv(1, 5'd6, 0, 0, 0, 0, 0,          1, 0, 0, 1, 32'h300, 0, 0));
    vecs.push_back(mkv(1, 5'd9, 0, 0, 0, 0, 0,          1, 0, 0, 1, 32'h300, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 32'h0, 32'h40, 0,    0, 1, 0, 1, 32'h300, 6, 32'h40));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 1, 32'h300, 0, 0));

    @(negedge clk);
    doReset("init");
    applyStimulus("idle");

    foreach (vecs[i]) begin
      v = vecs[i];
      iss_en = v.iss_en; iss_rd = v.iss_rd; fu_finish = v.fin; fu_is_jump = v.jmp;
      fu_pc_jump = v.pcj; fu_pc_wb = v.pcwb; wb_ready = v.rdy;
      applyStimulus($sformatf("vec%0d", i));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(v.e_busy));
      check($sformatf("vec%0d.wb_valid", i), 32'(wb_valid), 32'(v.e_wbv));
      check($sformatf("vec%0d.redirect_valid", i), 32'(redirect_valid), 32'(v.e_rv));
      check($sformatf("vec%0d.err", i), 32'(err), 32'(v.e_err));
      check($sformatf("vec%0d.redirect_pc", i), redirect_pc, v.e_rpc);
      if (v.e_wbv) begin
        check($sformatf("vec%0d.wb_rd", i), 32'(wb_rd), 32'(v.e_rd));
        check($sformatf("vec%0d.wb_data", i), wb_data, v.e_data);
      end
    end

    // Reset while a jump is in flight with one queued write
    doReset("midop_pre");
    iss_en = 1; iss_rd = 5'd7;
    applyStimulus("midop_iss1");
    clearInputs();
    fu_finish = 1; fu_is_jump = 1; fu_pc_jump = 32'h500; fu_pc_wb = 32'h70;
    applyStimulus("midop_fin1");
    clearInputs();
    iss_en = 1; iss_rd = 5'd8;
    applyStimulus("midop_iss2");
    check("midop.queued", 32'(wb_valid), 32'h1);
    check("midop.waiting", 32'(busy), 32'h1);
    doReset("midop");
    fu_finish = 1; fu_is_jump = 1; fu_pc_jump = 32'h600; fu_pc_wb = 32'h80; wb_ready = 1;
    applyStimulus("midop_late_fin");
    check("midop.late_err", 32'(err), 32'h1);
    check("midop.late_wb_valid", 32'(wb_valid), 32'h0);
    check("midop.late_redirect", 32'(redirect_valid), 32'h0);
    check("midop.late_redirect_pc", redirect_pc, 32'h0);
    clearInputs();
    applyStimulus("midop_after");

    // Randomized traffic with periodic resets to clear the sticky error
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 200 == 0) doReset($sformatf("rnd_rst%0d", cyc));
      iss_en     = ($urandom_range(0, 99) < 45);
      iss_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fu_finish  = m_pending ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
      fu_is_jump = $urandom_range(0, 1) == 1;
      fu_pc_jump = $urandom;
      fu_pc_wb   = $urandom;
      wb_ready   = ($urandom_range(0, 99) < 40);
      applyStimulus($sformatf("rnd%0d", cyc));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
